// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel-scan sequencer and its helpers.
package chan_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam int unsigned NUM_CH = 8;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

endpackage

// File: rtl/next_ch_find.sv
// Combinational search for the next set mask bit above the current channel,
// wrapping to the lowest set bit when none lies above.
module next_ch_find
  import chan_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [2:0]        cur,
  output logic [2:0]        nxt,
  output logic              wrap
);

  logic [2:0] above;
  logic [2:0] lowest;
  logic       found;

  // Descending scan so the last hit written is the lowest qualifying bit.
  always_comb begin
    above  = '0;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (mask[i-1]) begin
        lowest = 3'(i - 1);
        if ((i - 1) > 32'(cur)) begin
          above = 3'(i - 1);
          found = 1'b1;
        end
      end
    end
  end

  assign nxt  = found ? above : lowest;
  assign wrap = ~found;

endmodule

// File: rtl/chan_scan_seq.sv
// Channel-scan sequencer feeding a 3:8 decoder: walks a latched mask with a
// programmable dwell and one break-before-make gap cycle between channels.
module chan_scan_seq
  import chan_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic               hold,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         a,
  output logic [3:1]         e,
  output logic               busy,
  output logic               sweep_done
);

  state_e             state_q, state_d;
  logic [2:0]         a_q, a_d;
  logic [3:1]         e_q, e_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [7:0]         find_mask;
  logic [2:0]         find_cur;
  logic [2:0]         nxt;
  logic               wrap;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // In IDLE a search from the top channel yields the lowest set bit of the
  // incoming mask; otherwise search the latched mask above the held channel.
  assign find_mask = (state_q == IDLE) ? mask : mask_q;
  assign find_cur  = (state_q == IDLE) ? 3'(NUM_CH - 1) : a_q;

  next_ch_find u_find (
    .mask (find_mask),
    .cur  (find_cur),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      e_q          <= EN_OFF;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      cnt_q        <= '0;
      mask_q       <= '0;
      dwell_q      <= '0;
      cont_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      e_q          <= e_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cont_q       <= cont_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (start && (mask != '0)) state_d = ACTIVE;
        ACTIVE: if ((cnt_q == '0) && !hold) state_d = (!wrap || cont_q) ? GAP : IDLE;
        GAP:    state_d = ACTIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    a_d          = a_q;
    e_d          = e_q;
    sweep_done_d = 1'b0;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    dwell_d      = dwell_q;
    cont_d       = cont_q;
    if (stop) begin
      a_d   = '0;
      e_d   = EN_OFF;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (mask != '0)) begin
            mask_d  = mask;
            dwell_d = dwell_eff;
            cont_d  = cont;
            a_d     = nxt;
            e_d     = EN_ON;
            cnt_d   = dwell_eff - DWELL_W'(1);
          end
        end
        ACTIVE: begin
          if (cnt_q != '0) begin
            if (!hold) cnt_d = cnt_q - DWELL_W'(1);
          end else if (!hold) begin
            e_d = EN_OFF;
            if (wrap) begin
              sweep_done_d = 1'b1;
              if (!cont_q) a_d = '0;
            end
          end
        end
        GAP: begin
          a_d   = nxt;
          e_d   = EN_ON;
          cnt_d = dwell_q - DWELL_W'(1);
        end
        default: begin
          a_d = '0;
          e_d = EN_OFF;
        end
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  assign a          = a_q;
  assign e          = e_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq: cycle-by-cycle vector table plus
// hand-written reset and mid-dwell hold sequences, and decoder-facing checks.
module tb_chan_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic       hold;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] a;
  logic [3:1] e;
  logic       busy;
  logic       sweep_done;

  int n_cmp  = 0;
  int n_fail = 0;

  chan_scan_seq #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .hold       (hold),
    .mask       (mask),
    .dwell      (dwell),
    .a          (a),
    .e          (e),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sp;
    logic       ct;
    logic       hd;
    logic [7:0] msk;
    logic [7:0] dw;
    logic [2:0] xa;
    logic [2:0] xe;
    logic       xb;
    logic       xsd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic ct,
                              input logic hd, input logic [7:0] msk,
                              input logic [7:0] dw, input logic [2:0] xa,
                              input logic [2:0] xe, input logic xb,
                              input logic xsd);
    vec_t v;
    v.st = st; v.sp = sp; v.ct = ct; v.hd = hd; v.msk = msk; v.dw = dw;
    v.xa = xa; v.xe = xe; v.xb = xb; v.xsd = xsd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {a,e,busy,sd}=%b, want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic ct,
                       input logic hd, input logic [7:0] msk, input logic [7:0] dw);
    start = st; stop = sp; cont = ct; hold = hd; mask = msk; dwell = dw;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {a, e, busy, sweep_done};
  endfunction

  function automatic logic [7:0] exp_of(input logic [2:0] xa, input logic [2:0] xe,
                                        input logic xb, input logic xsd);
    return {xa, xe, xb, xsd};
  endfunction

  // Decoder-facing checks: legal enable codes, enable implies busy, and
  // the enable never stays on across an address change.
  logic       prev_v = 1'b0;
  logic [2:0] prev_a;
  logic [3:1] prev_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      n_cmp++;
      if (!((e == 3'b100) || (e == 3'b000)) || ((e == 3'b100) && !busy)) begin
        n_fail++;
        $display("FAIL dec_enable: got e=%b busy=%b, want e in {100,000} with busy when on", e, busy);
      end
      if (prev_v) begin
        n_cmp++;
        if ((prev_e == 3'b100) && (e == 3'b100) && (prev_a != a)) begin
          n_fail++;
          $display("FAIL dec_bbm: got a %0d->%0d with e=100 held, want a gap", prev_a, a);
        end
      end
      prev_v = 1'b1;
      prev_a = a;
      prev_e = e;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; stop = 0; cont = 0; hold = 0; mask = '0; dwell = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 8'h00);
    rst = 1'b0;

    // Single sweep 0,2,7 with dwell 3; a start and mask changes while busy are ignored.
    tbl.push_back(mk(1,0,0,0,8'h85,8'd3, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'hFF,8'd9, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,1,0));
    tbl.push_back(mk(0,0,1,0,8'h01,8'd9, 3'd2,3'b100,1,0));
    tbl.push_back(mk(1,0,1,0,8'h01,8'd9, 3'd2,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd2,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd2,3'b000,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,0,0));
    // Start with empty mask, then start+stop together: both stay idle.
    tbl.push_back(mk(1,0,1,0,8'h00,8'd4, 3'd0,3'b000,0,0));
    tbl.push_back(mk(1,1,1,0,8'hFF,8'd4, 3'd0,3'b000,0,0));
    // Continuous 8'h81 dwell 2: period 6, pulse in the gap after channel 7; stop there.
    tbl.push_back(mk(1,0,1,0,8'h81,8'd2, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b000,1,1));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd7,3'b100,1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,8'd0, 3'd0,3'b000,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,0,0));
    // Dwell 0 on channel 3 with hold for 4 cycles: enable on for 5 cycles.
    tbl.push_back(mk(1,0,0,0,8'h08,8'd0, 3'd3,3'b100,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8'd0, 3'd3,3'b100,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8'd0, 3'd3,3'b100,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8'd0, 3'd3,3'b100,1,0));
    tbl.push_back(mk(0,0,0,1,8'h00,8'd0, 3'd3,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd0,3'b000,0,0));
    // Single-bit continuous, dwell 1: ACTIVE/GAP alternate with a pulse every gap.
    tbl.push_back(mk(1,0,1,0,8'h10,8'd1, 3'd4,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd4,3'b000,1,1));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd4,3'b100,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,8'd0, 3'd4,3'b000,1,1));
    tbl.push_back(mk(0,1,0,0,8'h00,8'd0, 3'd0,3'b000,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].ct, tbl[i].hd, tbl[i].msk, tbl[i].dw);
      chk($sformatf("vec%0d", i), outs(), exp_of(tbl[i].xa, tbl[i].xe, tbl[i].xb, tbl[i].xsd));
    end

    // Reset held 3 cycles mid-scan, then a fresh sweep works.
    drive(1,0,1,0,8'h85,8'd3);
    chk("pre_rst_active", outs(), exp_of(3'd0, 3'b100, 1, 0));
    drive(0,0,0,0,8'h00,8'd0);
    drive(0,0,0,0,8'h00,8'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1,0,1,0,8'hFF,8'd5);
      chk($sformatf("rst_hold%0d", i), outs(), 8'h00);
    end
    rst = 1'b0;
    drive(0,0,0,0,8'h00,8'd0);
    chk("post_rst_idle", outs(), 8'h00);
    drive(1,0,0,0,8'h02,8'd1);
    chk("post_rst_start", outs(), exp_of(3'd1, 3'b100, 1, 0));
    drive(0,0,0,0,8'h00,8'd0);
    chk("post_rst_done", outs(), exp_of(3'd0, 3'b000, 0, 1));

    // Hold with counter nonzero: dwell 2 plus 2 hold cycles gives 4 enabled cycles.
    drive(1,0,0,0,8'h40,8'd2);
    chk("hold_mid_c0", outs(), exp_of(3'd6, 3'b100, 1, 0));
    drive(0,0,0,1,8'h00,8'd0);
    chk("hold_mid_c1", outs(), exp_of(3'd6, 3'b100, 1, 0));
    drive(0,0,0,1,8'h00,8'd0);
    chk("hold_mid_c2", outs(), exp_of(3'd6, 3'b100, 1, 0));
    drive(0,0,0,0,8'h00,8'd0);
    chk("hold_mid_c3", outs(), exp_of(3'd6, 3'b100, 1, 0));
    drive(0,0,0,0,8'h00,8'd0);
    chk("hold_mid_done", outs(), exp_of(3'd0, 3'b000, 0, 1));
    drive(0,0,0,0,8'h00,8'd0);
    chk("hold_mid_idle", outs(), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
